reset_sequencer: RTL and testbench

Watchdog-recovery reset sequencer that sits directly downstream of the auto-reset timer and consumes its `System_reset` pulse. On each trigger it asserts active-low resets to `NUM_DOMAINS` downstream domains (e.g. Ariane core, NVMe host interface, flash controller), then releases them one at a time, in index order. Each release waits for a minimum gap and for the previous domain's ready handshake. While a sequence is in progress it drives `timer_clear`, which the team wires to the timer's `Inner_counter_reset` so the watchdog cannot re-fire mid-recovery.

---
 rtl/reset_sequencer.sv | 152 +++++++++++++++
 tb/tb_reset_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Watchdog-recovery reset sequencer: holds every downstream domain in reset, then
// releases them one at a time in index order, gated by a minimum gap and a ready handshake.
module reset_sequencer #(
  parameter int NUM_DOMAINS   = 3,
  parameter int ASSERT_CYCLES = 16,
  parameter int STAGE_GAP     = 8,
  parameter int READY_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   System_reset,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] domain_rstn,
  output logic                   timer_clear,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic [NUM_DOMAINS-1:0] ready_err,
  output logic [7:0]             reset_count,
  output logic [1:0]             dbg_state_o
);

  // ASSERT_CYCLES is assumed not to exceed READY_TIMEOUT so the hold count fits in cnt.
  localparam int CW = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   sys_rst_q;
  logic                   counted_q, counted_d;
  logic [NUM_DOMAINS-1:0] domain_rstn_q, domain_rstn_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_DOMAINS-1:0] ready_err_q, ready_err_d;
  logic [7:0]             reset_count_q, reset_count_d;

  logic trig;
  logic gap_ok;
  logic rdy;
  logic tmo;
  logic advance;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    counted_d     = counted_q;
    ready_err_d   = ready_err_q;
    reset_count_d = reset_count_q;
    trig          = System_reset & ~sys_rst_q;
    gap_ok        = (cnt_q >= CW'(STAGE_GAP - 1));
    rdy           = domain_ready[idx_q];
    tmo           = (cnt_q == CW'(READY_TIMEOUT - 1));
    advance       = (gap_ok && rdy) || tmo;

    // A trigger always wins over whatever the current state would otherwise do.
    if (trig) begin
      state_d   = S_ASSERT;
      cnt_d     = '0;
      idx_d     = '0;
      counted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
        end
        S_ASSERT: begin
          if (cnt_q == CW'(ASSERT_CYCLES - 1)) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RELEASE: begin
          if (advance) begin
            if (!(gap_ok && rdy)) ready_err_d[idx_q] = 1'b1;
            cnt_d = '0;
            if (idx_q == IW'(NUM_DOMAINS - 1)) begin
              state_d = S_DONE;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_d   = S_IDLE;
          counted_d = 1'b0;
          // The power-on sequence is not a trigger and is not counted.
          if (counted_q && (reset_count_q != 8'hFF)) reset_count_d = reset_count_q + 8'd1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    domain_rstn_d = '1;
    if (state_d == S_ASSERT) begin
      domain_rstn_d = '0;
    end else if (state_d == S_RELEASE) begin
      for (int i = 0; i < NUM_DOMAINS; i++) domain_rstn_d[i] = (i <= int'(idx_d));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_ASSERT;
      cnt_q         <= '0;
      idx_q         <= '0;
      sys_rst_q     <= 1'b0;
      counted_q     <= 1'b0;
      domain_rstn_q <= '0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      ready_err_q   <= '0;
      reset_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      sys_rst_q     <= System_reset;
      counted_q     <= counted_d;
      domain_rstn_q <= domain_rstn_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ready_err_q   <= ready_err_d;
      reset_count_q <= reset_count_d;
    end
  end

  assign domain_rstn = domain_rstn_q;
  assign seq_busy    = busy_q;
  assign timer_clear = busy_q;
  assign seq_done    = done_q;
  assign ready_err   = ready_err_q;
  assign reset_count = reset_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a schedule model predicts every output change, a monitor
// pops and compares each observed change; counters and error flags are checked per scenario.
module tb_reset_sequencer;

  localparam int A  = 16;
  localparam int G  = 8;
  localparam int RT = 1024;
  localparam int EW = 38;

  typedef struct packed {
    logic [3:0][31:0] e;
    logic [2:0]       err;
  } sched_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       System_reset;
  logic [2:0] domain_ready;
  logic [2:0] domain_rstn;
  logic       timer_clear;
  logic       seq_busy;
  logic       seq_done;
  logic [2:0] ready_err;
  logic [7:0] reset_count;
  logic [1:0] dbg_state;

  int              cyc = 0;
  int              tests = 0;
  int              errors = 0;
  logic [EW-1:0]   exp_q[$];
  logic            mon_en = 1'b0;
  logic [5:0]      mon_prev = '0;
  logic [5:0]      model_val;
  int              model_cnt;
  logic [2:0]      model_err;

  reset_sequencer #(
    .NUM_DOMAINS(3), .ASSERT_CYCLES(A), .STAGE_GAP(G), .READY_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rstn(rstn), .System_reset(System_reset), .domain_ready(domain_ready),
    .domain_rstn(domain_rstn), .timer_clear(timer_clear), .seq_busy(seq_busy),
    .seq_done(seq_done), .ready_err(ready_err), .reset_count(reset_count),
    .dbg_state_o(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d, required finish", cyc);
    $fatal(1, "timeout");
  end

  // Release schedule from the rules: stage i is entered at e[i]; it advances on the first
  // cycle at least G-1 after entry where ready is high, or is forced at RT-1 after entry.
  function automatic sched_t calc(input int t0, input int d0, input int d1, input int d2);
    sched_t s;
    int     d[3];
    int     c;
    d[0] = d0; d[1] = d1; d[2] = d2;
    s.err = '0;
    s.e[0] = 32'(t0 + 1 + A);
    for (int i = 0; i < 3; i++) begin
      c = int'(s.e[i]) + G - 1;
      if (int'(s.e[i]) + d[i] > c) c = int'(s.e[i]) + d[i];
      if (c > int'(s.e[i]) + RT - 1) begin
        c = int'(s.e[i]) + RT - 1;
        s.err[i] = 1'b1;
      end
      s.e[i+1] = 32'(c + 1);
    end
    return s;
  endfunction

  // Expected {timer_clear, seq_busy, seq_done, domain_rstn} during cycle n of a sequence.
  function automatic logic [5:0] val_at(input int n, input sched_t s);
    if (n > int'(s.e[3]))  return 6'b000111;
    if (n == int'(s.e[3])) return 6'b111111;
    if (n >= int'(s.e[2])) return 6'b110111;
    if (n >= int'(s.e[1])) return 6'b110011;
    if (n >= int'(s.e[0])) return 6'b110001;
    return 6'b110000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Driver + model: one trigger (or power-on) with per-domain ready delays, optional re-trigger
  // roff cycles after the first one.
  task automatic run_scn(input int d0, input int d1, input int d2, input int hi,
                         input int roff, input bit por);
    int         t0, t1, endc, dd[3];
    sched_t     sa, sb, s;
    logic [5:0] v;
    bit         use_b;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    t0 = por ? cyc - 1 : cyc;
    use_b = (roff >= 0);
    t1 = t0 + roff;
    sa = calc(t0, d0, d1, d2);
    sb = use_b ? calc(t1, d0, d1, d2) : sa;
    endc = use_b ? int'(sb.e[3]) + 2 : int'(sa.e[3]) + 2;
    for (int n = t0 + 1; n <= endc; n++) begin
      v = (use_b && n > t1) ? val_at(n, sb) : val_at(n, sa);
      if (v != model_val) exp_q.push_back({32'(n), v});
      model_val = v;
    end
    if (!por && (!use_b || int'(sa.e[3]) < t1) && model_cnt < 255) model_cnt++;
    if (use_b && model_cnt < 255) model_cnt++;
    for (int i = 0; i < 3; i++)
      if (sa.err[i] && (!use_b || int'(sa.e[i+1]) <= t1)) model_err[i] = 1'b1;
    if (use_b) model_err = model_err | sb.err;
    for (int n = cyc; n <= endc; n++) begin
      if (n > cyc) begin
        @(posedge clk); #1;
      end
      System_reset = (!por && n >= t0 && n < t0 + hi) || (use_b && n >= t1 && n < t1 + hi);
      s = (use_b && n > t1) ? sb : sa;
      for (int i = 0; i < 3; i++) domain_ready[i] = (n >= int'(s.e[i]) + dd[i]);
    end
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d changes still unseen, expected 0", exp_q.size());
      exp_q.delete();
    end
    check("reset_count", 32'(reset_count), 32'(model_cnt));
    check("ready_err", 32'(ready_err), 32'(model_err));
  endtask

  // scoreboard monitor
  initial begin
    logic [5:0]    cur;
    logic [EW-1:0] exp;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {timer_clear, seq_busy, seq_done, domain_rstn};
        if (cur !== mon_prev) begin
          tests++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got cycle %0d value %b, expected no change", cyc, cur);
          end else begin
            exp = exp_q.pop_front();
            if ({32'(cyc), cur} !== exp) begin
              errors++;
              $display("FAIL output_change: got cycle %0d value %b, expected cycle %0d value %b",
                       cyc, cur, exp[EW-1:6], exp[5:0]);
            end
          end
          mon_prev = cur;
        end
      end
    end
  end

  initial begin
    int hi, roff;
    rstn = 1'b0;
    System_reset = 1'b0;
    domain_ready = 3'b111;
    model_cnt = 0;
    model_err = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rstn = 1'b1;
    check("rst_domain_rstn", 32'(domain_rstn), 32'h0);
    check("rst_seq_busy", 32'(seq_busy), 32'h1);
    check("rst_timer_clear", 32'(timer_clear), 32'h1);
    check("rst_seq_done", 32'(seq_done), 32'h0);
    check("rst_ready_err", 32'(ready_err), 32'h0);
    check("rst_reset_count", 32'(reset_count), 32'h0);
    model_val = 6'b110000;
    mon_prev = 6'b110000;
    mon_en = 1'b1;

    run_scn(0, 0, 0, 0, -1, 1'b1);            // power-on sequence
    run_scn(0, 0, 0, 5, -1, 1'b0);            // multi-cycle trigger counts once
    run_scn(0, 50, 0, 1, -1, 1'b0);           // late ready on domain 1
    run_scn(0, 0, 2000, 1, -1, 1'b0);         // domain 2 never ready
    run_scn(0, 0, 0, 2, -1, 1'b0);            // error flag survives a new trigger
    run_scn(0, 0, 0, 1, 1 + A + G + 3, 1'b0); // re-trigger while idx=1
    run_scn(0, 0, 0, 3, 8, 1'b0);             // re-trigger during the hold

    for (int k = 0; k < 12; k++) begin
      hi = int'($urandom_range(6, 1));
      roff = ($urandom_range(1, 0) == 1) ? int'($urandom_range(80, hi + 1)) : -1;
      run_scn(int'($urandom_range(20, 0)), int'($urandom_range(20, 0)),
              int'($urandom_range(20, 0)), hi, roff, 1'b0);
    end

    for (int k = 0; k < 260; k++)
      run_scn(int'($urandom_range(3, 0)), 0, int'($urandom_range(3, 0)), 1, -1, 1'b0);
    check("saturated_count", 32'(reset_count), 32'd255);

    // rstn in the middle of a release sequence
    mon_en = 1'b0;
    System_reset = 1'b1;
    @(posedge clk); #1;
    System_reset = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_domain_rstn", 32'(domain_rstn), 32'h0);
    check("mid_rst_seq_busy", 32'(seq_busy), 32'h1);
    check("mid_rst_timer_clear", 32'(timer_clear), 32'h1);
    check("mid_rst_seq_done", 32'(seq_done), 32'h0);
    check("mid_rst_ready_err", 32'(ready_err), 32'h0);
    check("mid_rst_reset_count", 32'(reset_count), 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
